// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: shares one registered unsigned multiplier between
// N_REQ requesters. Requests are granted round-robin, one operation is in
// flight at a time, and each product returns on a single response channel
// tagged with the index of the requester that owns it.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req_valid  per-requester request valid              [N_REQ]
//   req_ready  per-requester grant, at most one hot     [N_REQ]
//   req_a      packed operand A, requester i at [i*n +: n]
//   req_b      packed operand B, same packing
//   rsp_valid  product available
//   rsp_ready  consumer accepts the product
//   rsp_res    unsigned product a*b                     [2*n]
//   rsp_id     requester index owning rsp_res           [IDW]
//   busy       FSM is not idle
//   op_count   completed response handshakes, wraps     [16]
module mult_share_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned n     = 4,
    parameter int unsigned IDW   = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*n-1:0]   req_a,
    input  logic [N_REQ*n-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*n-1:0]       rsp_res,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy,
    output logic [15:0]          op_count
);

    localparam int unsigned PW  = 2 * n;
    localparam int unsigned CW  = 16;
    localparam int unsigned SW  = IDW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e          state_q,     state_d;
    logic [IDW-1:0]  rr_ptr_q,    rr_ptr_d;
    logic [IDW-1:0]  id_q,        id_d;
    logic [n-1:0]    a_q,         a_d;
    logic [n-1:0]    b_q,         b_d;
    logic [PW-1:0]   rsp_res_q,   rsp_res_d;
    logic [IDW-1:0]  rsp_id_q,    rsp_id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            busy_q,      busy_d;
    logic [CW-1:0]   op_count_q,  op_count_d;

    logic            gnt_found;
    logic [IDW-1:0]  gnt_idx;
    logic [SW-1:0]   cand;
    logic [PW-1:0]   product;
    logic [IDW-1:0]  rr_next;

    // Round-robin search: first valid index starting at rr_ptr, modulo N_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + SW'(k);
            if (cand >= SW'(N_REQ)) begin
                cand = cand - SW'(N_REQ);
            end
            if (!gnt_found && req_valid[cand[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IDW-1:0];
            end
        end
    end

    // Full-width product; both operands zero-extended so nothing is truncated.
    assign product = PW'(a_q) * PW'(b_q);

    // Pointer moves past the requester just served, wrapping at N_REQ-1.
    assign rr_next = (rsp_id_q == IDW'(N_REQ - 1)) ? '0 : rsp_id_q + IDW'(1);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output and datapath logic.
    always_comb begin
        req_ready   = '0;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_res_d   = rsp_res_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
        op_count_d  = op_count_q;
        busy_d      = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    // Grant is suppressed while reset is asserted.
                    req_ready[gnt_idx] = rst_n;
                    a_d                = req_a[gnt_idx*n +: n];
                    b_d                = req_b[gnt_idx*n +: n];
                    id_d               = gnt_idx;
                end
            end
            S_MUL: begin
                rsp_res_d   = product;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = rr_next;
                    op_count_d  = op_count_q + CW'(1);
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_res_q   <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            op_count_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_res_q   <= rsp_res_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            op_count_q  <= op_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = busy_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter (N_REQ=4, n=4): directed vectors with literal
// expectations, plus a behavioural model checked against the DUT each cycle.
module tb_mult_share_arbiter;

    localparam int NREQ = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_res;
    logic [1:0]  rsp_id;
    logic        busy;
    logic [15:0] op_count;

    int vectors     = 0;
    int miscompares = 0;
    bit model_on    = 1'b0;

    // Behavioural model: phase 0 waiting for a request, 1 multiplying,
    // 2 holding a product for the consumer.
    int          m_phase = 0;
    int          m_ptr   = 0;
    int          m_gid   = 0;
    int          m_id    = 0;
    int          m_a     = 0;
    int          m_b     = 0;
    bit          m_valid = 1'b0;
    logic [7:0]  m_res   = 8'd0;
    logic [15:0] m_cnt   = 16'd0;

    logic [3:0] gnt_tab  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] id_tab   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] prod_tab [5] = '{8'd6, 8'd20, 8'd42, 8'd99, 8'd6};

    always #5 clk = ~clk;

    mult_share_arbiter #(.N_REQ(4), .n(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_res   (rsp_res),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .op_count  (op_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    function automatic int find_grant(input logic [3:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // Per-cycle compare against the model, then advance the model one edge.
    always @(negedge clk) begin
        int g;
        logic [3:0] exp_rdy;
        if (model_on) begin
            g = find_grant(req_valid, m_ptr);
            exp_rdy = 4'b0000;
            if (rst_n && m_phase == 0 && g >= 0) exp_rdy[g] = 1'b1;
            chk("m_req_ready", req_ready, exp_rdy);
            chk("m_rsp_valid", rsp_valid, m_valid);
            chk("m_busy", busy, m_phase != 0);
            chk("m_op_count", op_count, m_cnt);
            if (m_valid) begin
                chk("m_rsp_res", rsp_res, m_res);
                chk("m_rsp_id", rsp_id, m_id);
            end
            if (!rst_n) begin
                m_phase = 0; m_ptr = 0; m_valid = 1'b0;
                m_res = 8'd0; m_id = 0; m_cnt = 16'd0;
            end else if (m_phase == 0) begin
                if (g >= 0) begin
                    m_a = int'(req_a[g*4 +: 4]);
                    m_b = int'(req_b[g*4 +: 4]);
                    m_gid = g;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_res = 8'(m_a * m_b);
                m_id = m_gid;
                m_valid = 1'b1;
                m_phase = 2;
            end else if (rsp_ready) begin
                m_valid = 1'b0;
                m_ptr = (m_id + 1) % NREQ;
                m_cnt = m_cnt + 16'd1;
                m_phase = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete operation starting from idle, consumer always ready.
    task automatic run_op(input logic [3:0] mask, input logic [15:0] ap, input logic [15:0] bp,
                          input logic [3:0] exp_gnt, input logic [1:0] exp_id,
                          input logic [7:0] exp_res);
        req_valid = mask; req_a = ap; req_b = bp; rsp_ready = 1'b1;
        @(negedge clk);
        chk("op_grant", req_ready, exp_gnt);
        tick();
        req_valid = 4'b0000;
        @(negedge clk);
        chk("op_mul_no_valid", rsp_valid, 1'b0);
        tick();
        @(negedge clk);
        chk("op_rsp_valid", rsp_valid, 1'b1);
        chk("op_rsp_res", rsp_res, exp_res);
        chk("op_rsp_id", rsp_id, exp_id);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req_valid = 4'b0000; req_a = 16'h0; req_b = 16'h0; rsp_ready = 1'b0;
        @(posedge clk); #1;
        model_on = 1'b1;
        req_valid = 4'b1111;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 4'b0000);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_op_count", op_count, 16'd0);
        chk("rst_rsp_res", rsp_res, 8'd0);
        chk("rst_rsp_id", rsp_id, 2'd0);
        tick();
        rst_n = 1'b1; req_valid = 4'b0000;

        // Single request from requester 1, then search resumes at index 2.
        run_op(4'b0010, 16'h0030, 16'h0050, 4'b0010, 2'd1, 8'd15);
        @(negedge clk);
        chk("single_op_count", op_count, 16'd1);
        tick();
        run_op(4'b1011, 16'h2000, 16'h3000, 4'b1000, 2'd3, 8'd6);

        // Round robin with all requesters asserting.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        req_valid = 4'b1111; req_a = 16'h9642; req_b = 16'hB753; rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rr_grant", req_ready, gnt_tab[k]);
            tick();
            tick();
            @(negedge clk);
            chk("rr_valid", rsp_valid, 1'b1);
            chk("rr_res", rsp_res, prod_tab[k]);
            chk("rr_id", rsp_id, id_tab[k]);
            tick();
        end
        req_valid = 4'b0000;

        // Backpressure with a competing request arriving mid-operation.
        req_valid = 4'b0100; req_a = 16'h0500; req_b = 16'h0600; rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_grant", req_ready, 4'b0100);
        tick();
        req_valid = 4'b0001; req_a = 16'h0503; req_b = 16'h0604;
        tick();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1'b1);
            chk("bp_res", rsp_res, 8'h1E);
            chk("bp_id", rsp_id, 2'd2);
            chk("bp_ready", req_ready, 4'b0000);
            chk("bp_busy", busy, 1'b1);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("bp_after_valid", rsp_valid, 1'b0);
        chk("bp_after_busy", busy, 1'b0);
        chk("bp_after_grant", req_ready, 4'b0001);
        chk("bp_after_count", op_count, 16'd6);
        tick();
        req_valid = 4'b0000;
        tick();
        @(negedge clk);
        chk("bp_next_res", rsp_res, 8'd12);
        chk("bp_next_id", rsp_id, 2'd0);
        tick();

        // Operand extremes.
        run_op(4'b0010, 16'h00F0, 16'h00F0, 4'b0010, 2'd1, 8'hE1);
        run_op(4'b0010, 16'h0000, 16'h00F0, 4'b0010, 2'd1, 8'h00);

        // Reset while holding a response.
        req_valid = 4'b0100; req_a = 16'h0700; req_b = 16'h0700; rsp_ready = 1'b0;
        @(negedge clk);
        chk("mr_grant", req_ready, 4'b0100);
        tick();
        req_valid = 4'b0000;
        tick();
        @(negedge clk);
        chk("mr_res", rsp_res, 8'h31);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_valid", rsp_valid, 1'b0);
        chk("mr_busy", busy, 1'b0);
        chk("mr_count", op_count, 16'd0);
        tick();
        run_op(4'b1001, 16'h5005, 16'h3003, 4'b0001, 2'd0, 8'd15);

        // Pointer wrap after requester 3.
        run_op(4'b1000, 16'h7000, 16'h8000, 4'b1000, 2'd3, 8'd56);
        run_op(4'b0011, 16'h00A6, 16'h0032, 4'b0001, 2'd0, 8'd12);
        run_op(4'b0001, 16'h0004, 16'h0009, 4'b0001, 2'd0, 8'd36);

        // Counter wrap: preload the count, then one more handshake.
        force dut.op_count_d = 16'hFFFF;
        tick();
        release dut.op_count_d;
        m_cnt = 16'hFFFF;
        @(negedge clk);
        chk("wrap_preload", op_count, 16'hFFFF);
        tick();
        run_op(4'b0100, 16'h0300, 16'h0300, 4'b0100, 2'd2, 8'd9);
        @(negedge clk);
        chk("wrap_count", op_count, 16'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
